// File: rtl/rocket_axi_pkg.sv
// Shared AXI encodings, slave FSM states and the address-decode helper
// used by the rocket AXI memory slave.
package rocket_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_WRESP = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  // Decode error wins over a bad transfer size; either one blocks the access.
  function automatic logic [1:0] addr_resp(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          bits,
                                           input logic [2:0]  size);
    logic [32:0] lim;
    lim = {1'b0, base} + (33'd1 << bits);
    if (({1'b0, addr} < {1'b0, base}) || ({1'b0, addr} >= lim)) return RESP_DECERR;
    if (size > 3'd3) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/rocket_axi_mem_bram.sv
// Single-port 64-bit RAM with per-byte write enables and a registered
// read port; read-before-write when both happen on the same cycle.
module rocket_axi_mem_bram #(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [7:0]           we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [63:0]          wdata,
  output logic [63:0]          rdata
);

  logic [63:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/rocket_axi_mem_slave.sv
// AXI4 memory slave serving one burst at a time from a single-port RAM.
// Handshakes: a beat transfers on a rising edge where valid and ready are both high; valid never waits on ready.
module rocket_axi_mem_slave
  import rocket_axi_pkg::*;
#(
  parameter logic [31:0] C_MEM_BASE         = 32'h0000_0000,
  parameter int          C_MEM_BITS         = 12,
  parameter int          C_S_AXI_ID_WIDTH   = 6,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 64
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [C_S_AXI_ID_WIDTH-1:0] s_axi_awid,
  input  logic [31:0]                 s_axi_awaddr,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_awlock,
  input  logic [3:0]                  s_axi_awcache,
  input  logic [2:0]                  s_axi_awprot,
  input  logic [3:0]                  s_axi_awqos,
  input  logic [3:0]                  s_axi_awregion,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [63:0]                 s_axi_wdata,
  input  logic [7:0]                  s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0]                 s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic                        s_axi_arlock,
  input  logic [3:0]                  s_axi_arcache,
  input  logic [2:0]                  s_axi_arprot,
  input  logic [3:0]                  s_axi_arqos,
  input  logic [3:0]                  s_axi_arregion,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0] s_axi_rid,
  output logic [63:0]                 s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [1:0]                  dbg_state
);

  localparam int WBITS = C_MEM_BITS - 3;

  state_t                      state;
  logic [C_S_AXI_ID_WIDTH-1:0] id_q;
  logic [WBITS-1:0]            idx_q;
  logic [7:0]                  len_q, cnt_q;
  logic                        fixed_q, wlast_bad, prio_rd, pend;
  logic [1:0]                  resp_q;
  logic [8:0]                  fetch_left;
  logic [31:0]                 aw_off, ar_off;
  logic [63:0]                 bram_q;
  logic                        aw_go, ar_go, w_go, beat_last, r_load, fetch;

  assign aw_off    = s_axi_awaddr - C_MEM_BASE;
  assign ar_off    = s_axi_araddr - C_MEM_BASE;
  assign dbg_state = state;

  // Ready is withheld from the loser so two handshakes can never land together.
  assign s_axi_awready = (state == S_IDLE) && s_axi_aresetn && !(prio_rd && s_axi_arvalid);
  assign s_axi_arready = (state == S_IDLE) && s_axi_aresetn && !(!prio_rd && s_axi_awvalid);
  assign s_axi_wready  = (state == S_WDATA);

  assign aw_go     = s_axi_awvalid && s_axi_awready;
  assign ar_go     = s_axi_arvalid && s_axi_arready;
  assign w_go      = s_axi_wvalid && s_axi_wready;
  assign beat_last = (cnt_q == len_q);
  // pend marks that the RAM output already holds the next beat to present.
  assign r_load    = (state == S_RDATA) && pend && (!s_axi_rvalid || s_axi_rready);
  assign fetch     = (state == S_RDATA) && (fetch_left != 9'd0) && (!pend || r_load);

  rocket_axi_mem_bram #(.ADDR_BITS(WBITS)) u_bram (
    .clk   (s_axi_aclk),
    .en    (w_go || fetch),
    .we    ((w_go && resp_q == RESP_OKAY) ? s_axi_wstrb : 8'h00),
    .addr  (idx_q),
    .wdata (s_axi_wdata),
    .rdata (bram_q)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state        <= S_IDLE;
      id_q         <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      fixed_q      <= 1'b0;
      wlast_bad    <= 1'b0;
      prio_rd      <= 1'b0;
      pend         <= 1'b0;
      resp_q       <= RESP_OKAY;
      fetch_left   <= '0;
      s_axi_bid    <= '0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_bvalid <= 1'b0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rlast  <= 1'b0;
      s_axi_rvalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (aw_go) begin
            id_q      <= s_axi_awid;
            idx_q     <= aw_off[C_MEM_BITS-1:3];
            len_q     <= s_axi_awlen;
            cnt_q     <= '0;
            fixed_q   <= (s_axi_awburst == BURST_FIXED);
            resp_q    <= addr_resp(s_axi_awaddr, C_MEM_BASE, C_MEM_BITS, s_axi_awsize);
            wlast_bad <= 1'b0;
            if (s_axi_arvalid) prio_rd <= ~prio_rd;
            state     <= S_WDATA;
          end else if (ar_go) begin
            id_q       <= s_axi_arid;
            idx_q      <= ar_off[C_MEM_BITS-1:3];
            len_q      <= s_axi_arlen;
            cnt_q      <= '0;
            fixed_q    <= (s_axi_arburst == BURST_FIXED);
            resp_q     <= addr_resp(s_axi_araddr, C_MEM_BASE, C_MEM_BITS, s_axi_arsize);
            fetch_left <= {1'b0, s_axi_arlen} + 9'd1;
            pend       <= 1'b0;
            if (s_axi_awvalid) prio_rd <= ~prio_rd;
            state      <= S_RDATA;
          end
        end
        S_WDATA: begin
          if (w_go) begin
            if (!fixed_q) idx_q <= idx_q + 1'b1;
            cnt_q <= cnt_q + 8'd1;
            if (s_axi_wlast != beat_last) wlast_bad <= 1'b1;
            if (beat_last) begin
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= id_q;
              if (resp_q != RESP_OKAY) s_axi_bresp <= resp_q;
              else if (wlast_bad || !s_axi_wlast) s_axi_bresp <= RESP_SLVERR;
              else s_axi_bresp <= RESP_OKAY;
              state <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_RDATA: begin
          if (fetch) begin
            if (!fixed_q) idx_q <= idx_q + 1'b1;
            fetch_left <= fetch_left - 9'd1;
            pend       <= 1'b1;
          end else if (r_load) begin
            pend <= 1'b0;
          end
          if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            if (s_axi_rlast) state <= S_IDLE;
          end
          if (r_load) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rid    <= id_q;
            s_axi_rdata  <= (resp_q == RESP_DECERR) ? 64'h0 : bram_q;
            s_axi_rresp  <= resp_q;
            s_axi_rlast  <= beat_last;
            cnt_q        <= cnt_q + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion,
                       aw_off[31:C_MEM_BITS], aw_off[2:0], ar_off[31:C_MEM_BITS], ar_off[2:0]};

endmodule

// File: tb/tb_rocket_axi_mem_slave.sv
// Directed bench for rocket_axi_mem_slave: drivers push expected B/R responses,
// a negedge monitor pops and compares them as the slave presents them.
module tb_rocket_axi_mem_slave;
  import rocket_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h0;
  localparam int IDW = 6;
  localparam int RW  = IDW + 64 + 2 + 1;
  localparam int BW  = IDW + 2;

  logic s_axi_aclk, s_axi_aresetn;
  logic [IDW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp, dbg_state;
  logic        s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [63:0] s_axi_wdata, s_axi_rdata;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_rlast, s_axi_rvalid, s_axi_rready;

  logic [BW-1:0] exp_b_q[$];
  logic [RW-1:0] exp_r_q[$];
  logic [63:0]   mem_model [512];
  logic [63:0]   wbuf [16];
  logic [7:0]    sbuf [16];
  logic          lbuf [16];
  int  n_cmp, n_fail;
  bit  toggle_mode;

  rocket_axi_mem_slave dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
    .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0), .s_axi_awregion(4'h0),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0), .s_axi_arregion(4'h0),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    s_axi_aclk = 1'b0;
    forever #5 s_axi_aclk = ~s_axi_aclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi_rready = 1'b1;
    forever begin
      @(posedge s_axi_aclk);
      #1;
      s_axi_rready = toggle_mode ? ~s_axi_rready : 1'b1;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [RW-1:0] r_held, r_now;
    bit r_hold_valid;
    r_hold_valid = 1'b0;
    r_held = '0;
    forever begin
      @(negedge s_axi_aclk);
      if (!s_axi_aresetn) begin
        r_hold_valid = 1'b0;
      end else begin
        if (s_axi_bvalid && s_axi_bready) begin
          if (exp_b_q.size() == 0) check("b_unexpected", 128'(s_axi_bvalid), 128'(0));
          else check("b_resp", 128'({s_axi_bid, s_axi_bresp}), 128'(exp_b_q.pop_front()));
        end
        r_now = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
        if (s_axi_rvalid) begin
          if (r_hold_valid) check("r_stable", 128'(r_now), 128'(r_held));
          if (s_axi_rready) begin
            r_hold_valid = 1'b0;
            if (exp_r_q.size() == 0) check("r_unexpected", 128'(s_axi_rvalid), 128'(0));
            else check("r_beat", 128'(r_now), 128'(exp_r_q.pop_front()));
          end else begin
            r_hold_valid = 1'b1;
            r_held = r_now;
          end
        end else begin
          r_hold_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic do_aw(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    t = 0;
    do begin @(negedge s_axi_aclk); t++; end while (!s_axi_awready && t < 100);
    if (!s_axi_awready) check("aw_timeout", 128'(s_axi_awready), 128'(1));
    @(posedge s_axi_aclk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    t = 0;
    do begin @(negedge s_axi_aclk); t++; end while (!s_axi_arready && t < 100);
    if (!s_axi_arready) check("ar_timeout", 128'(s_axi_arready), 128'(1));
    @(posedge s_axi_aclk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int t;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    t = 0;
    do begin @(negedge s_axi_aclk); t++; end while (!s_axi_wready && t < 100);
    if (!s_axi_wready) check("w_timeout", 128'(s_axi_wready), 128'(1));
    @(posedge s_axi_aclk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0 || dbg_state != 2'd0) && t < 400) begin
      @(posedge s_axi_aclk); #1; t++;
    end
    if (t >= 400) check("drain_timeout", 128'(exp_b_q.size() + exp_r_q.size()), 128'(0));
  endtask

  function automatic int word_idx(input logic [31:0] addr);
    return int'((addr - BASE) >> 3) & 511;
  endfunction

  task automatic model_write(input int idx, input logic [63:0] data, input logic [7:0] strb);
    for (int b = 0; b < 8; b++) if (strb[b]) mem_model[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic fill_beats(input int len, input logic [63:0] base_data, input logic [7:0] strb);
    for (int i = 0; i <= len; i++) begin
      wbuf[i] = base_data + 64'(i);
      sbuf[i] = strb;
      lbuf[i] = (i == len);
    end
  endtask

  task automatic write_burst(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [1:0] exp_resp, input bit apply);
    int idx;
    idx = word_idx(addr);
    exp_b_q.push_back({id, exp_resp});
    do_aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      do_w(wbuf[i], sbuf[i], lbuf[i]);
      if (apply) model_write(idx, wbuf[i], sbuf[i]);
      if (burst != BURST_FIXED) idx = (idx + 1) % 512;
    end
    wait_drain();
  endtask

  task automatic push_reads(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] exp_resp);
    int idx;
    idx = word_idx(addr);
    for (int i = 0; i <= int'(len); i++) begin
      exp_r_q.push_back({id, (exp_resp == RESP_DECERR) ? 64'h0 : mem_model[idx], exp_resp,
                         1'(i == int'(len))});
      if (burst != BURST_FIXED) idx = (idx + 1) % 512;
    end
  endtask

  task automatic read_burst(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [1:0] exp_resp);
    push_reads(id, addr, len, burst, exp_resp);
    do_ar(id, addr, len, 3'd3, burst);
    wait_drain();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    n_cmp = 0; n_fail = 0; toggle_mode = 1'b0;
    for (int i = 0; i < 512; i++) mem_model[i] = 64'h0;
    s_axi_aresetn = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;

    // reset state
    repeat (3) @(posedge s_axi_aclk);
    #1;
    check("rst_ready", 128'({s_axi_awready, s_axi_arready, s_axi_wready}), 128'(0));
    check("rst_valid", 128'({s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 128'(0));
    check("rst_data", 128'({s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rdata}), 128'(0));
    s_axi_aresetn = 1'b1;
    @(negedge s_axi_aclk);
    check("post_rst_ready", 128'({s_axi_awready, s_axi_arready}), 128'(2'b11));
    @(posedge s_axi_aclk); #1;

    // simultaneous AW/AR after reset: write first, the held read follows and sees new data
    model_write(word_idx(32'h100), 64'h1122334455667788, 8'hFF);
    exp_b_q.push_back({6'd1, RESP_OKAY});
    exp_r_q.push_back({6'd2, 64'h1122334455667788, RESP_OKAY, 1'b1});
    s_axi_awid = 6'd1; s_axi_awaddr = 32'h100; s_axi_awlen = 8'd0; s_axi_awsize = 3'd3;
    s_axi_awburst = BURST_INCR; s_axi_awvalid = 1'b1;
    s_axi_arid = 6'd2; s_axi_araddr = 32'h100; s_axi_arlen = 8'd0; s_axi_arsize = 3'd3;
    s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    @(negedge s_axi_aclk);
    check("grant1", 128'({s_axi_awready, s_axi_arready}), 128'(2'b10));
    @(posedge s_axi_aclk); #1;
    s_axi_awvalid = 1'b0;
    do_w(64'h1122334455667788, 8'hFF, 1'b1);
    t = 0;
    do begin @(negedge s_axi_aclk); t++; end while (!s_axi_arready && t < 100);
    check("grant1_read_after", 128'(s_axi_arready), 128'(1));
    @(posedge s_axi_aclk); #1;
    s_axi_arvalid = 1'b0;
    wait_drain();

    // second simultaneous request: read wins
    model_write(word_idx(32'h108), 64'h0F0E0D0C0B0A0908, 8'hFF);
    exp_r_q.push_back({6'd3, 64'h1122334455667788, RESP_OKAY, 1'b1});
    exp_b_q.push_back({6'd4, RESP_OKAY});
    s_axi_arid = 6'd3; s_axi_araddr = 32'h100; s_axi_arvalid = 1'b1;
    s_axi_awid = 6'd4; s_axi_awaddr = 32'h108; s_axi_awvalid = 1'b1;
    @(negedge s_axi_aclk);
    check("grant2", 128'({s_axi_awready, s_axi_arready}), 128'(2'b01));
    @(posedge s_axi_aclk); #1;
    s_axi_arvalid = 1'b0;
    t = 0;
    do begin @(negedge s_axi_aclk); t++; end while (!s_axi_awready && t < 100);
    check("grant2_write_after", 128'(s_axi_awready), 128'(1));
    @(posedge s_axi_aclk); #1;
    s_axi_awvalid = 1'b0;
    do_w(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1);
    wait_drain();

    // read latency: rvalid first seen two cycles after the AR handshake
    exp_r_q.push_back({6'd5, 64'h0F0E0D0C0B0A0908, RESP_OKAY, 1'b1});
    do_ar(6'd5, 32'h108, 8'd0, 3'd3, BURST_INCR);
    @(negedge s_axi_aclk);
    @(negedge s_axi_aclk);
    check("rlat_1cyc", 128'(s_axi_rvalid), 128'(0));
    @(negedge s_axi_aclk);
    check("rlat_2cyc", 128'(s_axi_rvalid), 128'(1));
    @(posedge s_axi_aclk); #1;
    wait_drain();

    // 8-beat INCR write, read back with rready toggling
    fill_beats(7, 64'hCAFE0200_00000000, 8'hFF);
    write_burst(6'd6, 32'h200, 8'd7, 3'd3, BURST_INCR, RESP_OKAY, 1'b1);
    toggle_mode = 1'b1;
    read_burst(6'd7, 32'h200, 8'd7, BURST_INCR, RESP_OKAY);
    toggle_mode = 1'b0;
    repeat (2) @(posedge s_axi_aclk);
    #1;

    // INCR wraps modulo the window: 0xFF8 then 0x000
    fill_beats(1, 64'h5A5A0FF8_00000000, 8'hFF);
    write_burst(6'd8, 32'hFF8, 8'd1, 3'd3, BURST_INCR, RESP_OKAY, 1'b1);
    read_burst(6'd9, 32'h000, 8'd0, BURST_INCR, RESP_OKAY);
    read_burst(6'd10, 32'hFF8, 8'd0, BURST_INCR, RESP_OKAY);

    // out-of-window write is dropped; out-of-window read returns zeros
    fill_beats(0, 64'hDEADBEEF_DEADBEEF, 8'hFF);
    write_burst(6'd11, BASE + 32'h1000, 8'd0, 3'd3, BURST_INCR, RESP_DECERR, 1'b0);
    read_burst(6'd12, 32'h000, 8'd0, BURST_INCR, RESP_OKAY);
    read_burst(6'd13, BASE + 32'h1000, 8'd3, BURST_INCR, RESP_DECERR);

    // oversize beat: SLVERR, write dropped
    fill_beats(0, 64'hBADBAD00_00000000, 8'hFF);
    write_burst(6'd14, 32'h108, 8'd0, 3'd4, BURST_INCR, RESP_SLVERR, 1'b0);
    read_burst(6'd15, 32'h108, 8'd0, BURST_INCR, RESP_OKAY);

    // early wlast plus partial strobes
    fill_beats(3, 64'h44444444_00000000, 8'hFF);
    write_burst(6'd16, 32'h400, 8'd3, 3'd3, BURST_INCR, RESP_OKAY, 1'b1);
    fill_beats(3, 64'hDDDDDDDD_EEEEEEE0, 8'h0F);
    for (int i = 0; i < 4; i++) lbuf[i] = (i == 1);
    write_burst(6'd17, 32'h400, 8'd3, 3'd3, BURST_INCR, RESP_SLVERR, 1'b1);
    read_burst(6'd18, 32'h400, 8'd3, BURST_INCR, RESP_OKAY);

    // FIXED burst keeps the address
    fill_beats(1, 64'h600F1ED0_00000000, 8'hFF);
    write_burst(6'd19, 32'h600, 8'd1, 3'd3, BURST_FIXED, RESP_OKAY, 1'b1);
    read_burst(6'd20, 32'h600, 8'd0, BURST_INCR, RESP_OKAY);

    // reset after beat 3 of an 8-beat write: beats 4..8 must not land
    fill_beats(7, 64'hAAAA0300_00000000, 8'hFF);
    write_burst(6'd21, 32'h300, 8'd7, 3'd3, BURST_INCR, RESP_OKAY, 1'b1);
    fill_beats(7, 64'hBBBB0300_00000000, 8'hFF);
    do_aw(6'd22, 32'h300, 8'd7, 3'd3, BURST_INCR);
    for (int i = 0; i < 3; i++) begin
      do_w(wbuf[i], sbuf[i], lbuf[i]);
      model_write(word_idx(32'h300) + i, wbuf[i], sbuf[i]);
    end
    s_axi_wdata = wbuf[3]; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    check("midrst_ready", 128'({s_axi_awready, s_axi_arready, s_axi_wready}), 128'(0));
    check("midrst_valid", 128'({s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 128'(0));
    s_axi_wvalid = 1'b0;
    repeat (2) @(posedge s_axi_aclk);
    #1;
    s_axi_aresetn = 1'b1;
    @(negedge s_axi_aclk);
    check("midrst_release", 128'({s_axi_awready, s_axi_arready}), 128'(2'b11));
    @(posedge s_axi_aclk); #1;
    read_burst(6'd23, 32'h300, 8'd7, BURST_INCR, RESP_OKAY);

    repeat (3) @(posedge s_axi_aclk);
    check("queues_empty", 128'(exp_b_q.size() + exp_r_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rocket_axi_mem_slave.md
ROCKET_AXI_MEM_SLAVE -- requirements
Module: rocket_axi_mem_slave

Interface
REQ-001 SHALL have parameter C_MEM_BASE, default 32'h0000_0000, byte base address of the memory window.
REQ-002 SHALL have parameter C_MEM_BITS, default 12, log2 of window bytes (4 KiB, 512 x 64-bit words).
REQ-003 SHALL have parameters C_S_AXI_ID_WIDTH 6, C_S_AXI_ADDR_WIDTH 32, C_S_AXI_DATA_WIDTH 64 (fixed at 64).
REQ-004 SHALL have port s_axi_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port s_axi_aresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have AW inputs s_axi_awid[ID], awaddr[32], awlen[8], awsize[3], awburst[2], awvalid; output awready.
REQ-007 SHALL have W inputs s_axi_wdata[64], wstrb[8], wlast, wvalid; output wready.
REQ-008 SHALL have B outputs s_axi_bid[ID], bresp[2], bvalid; input bready.
REQ-009 SHALL have AR inputs s_axi_arid[ID], araddr[32], arlen[8], arsize[3], arburst[2], arvalid; output arready.
REQ-010 SHALL have R outputs s_axi_rid[ID], rdata[64], rresp[2], rlast, rvalid; input rready.
REQ-011 SHALL accept awlock/awcache/awprot/awqos/awregion and the ar equivalents as inputs and ignore them.

Function
REQ-012 SHALL serve one transaction at a time; FSM states IDLE, WDATA, WRESP, RDATA.
REQ-013 IDLE: awready/arready high only in IDLE; if both awvalid and arvalid, grant alternates, write first after reset.
REQ-014 AW handshake SHALL latch id, addr, len, burst, then enter WDATA; wready high throughout WDATA.
REQ-015 Each W handshake SHALL write bytes enabled by wstrb to word addr[C_MEM_BITS-1:3], then advance the address.
REQ-016 Address advance: INCR and WRAP add 8 (WRAP treated as INCR); FIXED keeps address; wraps modulo window, no error.
REQ-017 Beat counter SHALL end the burst after awlen+1 beats; WDATA then goes to WRESP regardless of wlast.
REQ-018 wlast mismatch (asserted early, or missing on final beat) SHALL set bresp SLVERR (2'b10); data still written.
REQ-019 Address outside [C_MEM_BASE, C_MEM_BASE+2^C_MEM_BITS) or awsize>3 SHALL suppress all writes and give DECERR (2'b11) / SLVERR respectively.
REQ-020 WRESP: bvalid high with latched bid until bready; then IDLE, next grant available the following cycle.
REQ-021 AR handshake SHALL enter RDATA; first rvalid exactly 2 cycles after handshake; with rready held high, one beat per cycle.
REQ-022 rvalid/rdata/rresp/rlast SHALL stay stable while rvalid and !rready; rlast on beat arlen+1 only.
REQ-023 Out-of-window read SHALL return rdata 0, rresp DECERR every beat; arsize>3 gives SLVERR; otherwise OKAY.
REQ-024 After last R handshake SHALL return to IDLE; a read after a write to the same word SHALL return the new data.

Reset
REQ-025 On s_axi_aresetn low SHALL immediately clear awready, wready, bvalid, arready, rvalid, rlast and enter IDLE; bresp/rresp/bid/rid/rdata 0.
REQ-026 Reset mid-burst SHALL abandon the transaction without further writes; memory contents are not cleared.
REQ-027 First cycle after reset release SHALL present awready and arready high.

Structure
REQ-028 Shared package rocket_axi_pkg SHALL hold AXI response codes (OKAY, EXOKAY, SLVERR, DECERR), burst codes and FSM state enum.
REQ-029 Memory SHALL be one sub-module rocket_axi_mem_bram: 1 port, byte-write enables, registered 1-cycle read, inferable as block RAM.

Verification
REQ-030 Single write 0x100 data 0x1122334455667788 strb 0xFF, then read 0x100 -> bresp OKAY, rdata 0x1122334455667788, rlast 1.
REQ-031 INCR write awlen 7 at 0x200, then read awlen 7 with rready toggling 1/0 -> 8 beats in order, rlast on 8th, data stable on stalls.
REQ-032 Simultaneous awvalid and arvalid after reset -> write granted first; next simultaneous request -> read granted first.
REQ-033 Write to C_MEM_BASE+0x1000 -> bresp DECERR, memory unchanged; read there with arlen 3 -> 4 beats rdata 0 DECERR.
REQ-034 Write awlen 3 with wlast on beat 2 -> 4 beats accepted, bresp SLVERR; partial strb 0x0F writes only bytes 3:0.
REQ-035 Assert reset during beat 3 of 8-beat write -> outputs cleared same cycle, beats 4-8 never written, awready high after release.
